// File: rtl/key_debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_debounce_multi : N-channel push-button synchroniser/debouncer with     |
// | press/release pulses; optional long-press via `define KEY_LONG_PRESS_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_debounce_multi #(
  parameter int   N           = 4,
  parameter int   DEB_CYCLES  = 240000,
  parameter int   CNT_W       = 20,
  parameter logic PRESS_LEVEL = 1'b0,
  parameter int   HOLD_CYCLES = 2400000,
  parameter int   HOLD_W      = 22
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic [N-1:0] key_i,
  output logic [N-1:0] key_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] long_o,
  output logic         any_press_o
);

  localparam logic [CNT_W-1:0] c_deb_last    = CNT_W'(DEB_CYCLES - 1);
  localparam logic             c_hold_cfg_ok = (HOLD_CYCLES >= 1) && (HOLD_W >= 1);

  logic [N-1:0] w_press_set;

  generate
    for (genvar i = 0; i < N; i++) begin : g_ch
      logic             r_s1;
      logic             r_s;
      logic [CNT_W-1:0] r_cnt;
      logic             r_key;
      logic             r_press;
      logic             r_release;
      logic             w_differ;
      logic             w_fire;

      assign w_differ = (r_s != r_key);
      assign w_fire   = w_differ && (r_cnt == c_deb_last);

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_s1      <= ~PRESS_LEVEL;
          r_s       <= ~PRESS_LEVEL;
          r_cnt     <= '0;
          r_key     <= ~PRESS_LEVEL;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_s1      <= key_i[i];
          r_s       <= r_s1;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          // Any sample matching the current output restarts the window.
          if (!w_differ) begin
            r_cnt <= '0;
          end else if (w_fire) begin
            r_key     <= r_s;
            r_cnt     <= '0;
            r_press   <= (r_s == PRESS_LEVEL);
            r_release <= (r_s != PRESS_LEVEL);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign key_o[i]       = r_key;
      assign press_o[i]     = r_press;
      assign release_o[i]   = r_release;
      assign w_press_set[i] = w_fire && (r_s == PRESS_LEVEL);

`ifdef KEY_LONG_PRESS_EN
      localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYCLES - 1);

      logic [HOLD_W-1:0] r_hold;
      logic              r_long;
      logic              r_long_done;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_hold      <= '0;
          r_long      <= 1'b0;
          r_long_done <= 1'b0;
        end else begin
          r_long <= 1'b0;
          if (r_key != PRESS_LEVEL) begin
            r_hold      <= '0;
            r_long_done <= 1'b0;
          end else if (!r_long_done) begin
            // Fires once, then the counter holds until the key is released.
            if (r_hold == c_hold_last) begin
              r_long      <= 1'b1;
              r_long_done <= 1'b1;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
      end

      assign long_o[i] = r_long;
`else
      assign long_o[i] = 1'b0 & c_hold_cfg_ok;
`endif
    end
  endgenerate

  // Registered from the same edge condition, so it lines up with press_o.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      any_press_o <= 1'b0;
    end else begin
      any_press_o <= |w_press_set;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_debounce_multi : directed self-checking bench, N=4, DEB_CYCLES=4.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_key_debounce_multi;

  localparam int N = 4;
`ifdef KEY_LONG_PRESS_EN
  localparam logic [3:0] c_long_exp = 4'b0001;
`else
  localparam logic [3:0] c_long_exp = 4'b0000;
`endif

  logic         sys_clk;
  logic         sys_rst_n;
  logic [N-1:0] key_i;
  logic [N-1:0] key_o;
  logic [N-1:0] press_o;
  logic [N-1:0] release_o;
  logic [N-1:0] long_o;
  logic         any_press_o;

  int checks   = 0;
  int failures = 0;

  key_debounce_multi #(
    .N(N), .DEB_CYCLES(4), .CNT_W(3), .PRESS_LEVEL(1'b0),
    .HOLD_CYCLES(10), .HOLD_W(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_i(key_i),
    .key_o(key_o), .press_o(press_o), .release_o(release_o),
    .long_o(long_o), .any_press_o(any_press_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then park at the following falling edge.
  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  logic seen_p1;
  logic seen_long;

  initial begin
    sys_rst_n = 1'b0;
    key_i     = 4'hF;
    repeat (3) tick();
    check_val("rst_key",   32'(key_o),       32'hF);
    check_val("rst_press", 32'(press_o),     32'h0);
    check_val("rst_rel",   32'(release_o),   32'h0);
    check_val("rst_long",  32'(long_o),      32'h0);
    check_val("rst_any",   32'(any_press_o), 32'h0);
    sys_rst_n = 1'b1;
    repeat (8) tick();
    check_val("idle_key",   32'(key_o),   32'hF);
    check_val("idle_press", 32'(press_o), 32'h0);

    // Press ch0: new key_o at edge k+5, pulse for exactly one cycle.
    key_i = 4'b1110;
    repeat (5) tick();
    check_val("p0_early_key",   32'(key_o),   32'hF);
    check_val("p0_early_press", 32'(press_o), 32'h0);
    tick();
    check_val("p0_key",   32'(key_o),       32'hE);
    check_val("p0_press", 32'(press_o),     32'h1);
    check_val("p0_any",   32'(any_press_o), 32'h1);
    check_val("p0_rel",   32'(release_o),   32'h0);
    tick();
    check_val("p0_press_off", 32'(press_o),     32'h0);
    check_val("p0_any_off",   32'(any_press_o), 32'h0);

    // Ch1 glitches of 3 low cycles never get through.
    seen_p1 = 1'b0;
    for (int g = 0; g < 5; g++) begin
      key_i[1] = 1'b0;
      repeat (3) begin tick(); seen_p1 |= press_o[1] | release_o[1]; end
      key_i[1] = 1'b1;
      repeat (3) begin tick(); seen_p1 |= press_o[1] | release_o[1]; end
      check_val("glitch_key1", 32'(key_o[1]), 32'h1);
    end
    check_val("glitch_pulse1", 32'(seen_p1), 32'h0);

    // Release ch0.
    key_i = 4'hF;
    repeat (5) tick();
    check_val("r0_early_rel", 32'(release_o), 32'h0);
    tick();
    check_val("r0_rel",   32'(release_o), 32'h1);
    check_val("r0_press", 32'(press_o),   32'h0);
    check_val("r0_key",   32'(key_o),     32'hF);
    tick();
    check_val("r0_rel_off", 32'(release_o), 32'h0);

    // Ch2 and ch3 pressed together.
    key_i = 4'b0011;
    repeat (6) tick();
    check_val("p23_press", 32'(press_o),     32'hC);
    check_val("p23_any",   32'(any_press_o), 32'h1);
    check_val("p23_key",   32'(key_o),       32'h3);
    tick();
    check_val("p23_press_off", 32'(press_o),     32'h0);
    check_val("p23_any_off",   32'(any_press_o), 32'h0);
    key_i = 4'hF;
    repeat (6) tick();
    check_val("r23_rel", 32'(release_o), 32'hC);
    repeat (3) tick();

    // Long hold on ch0: long_o 10 cycles after press_o, no repeat.
    key_i = 4'b1110;
    repeat (6) tick();
    check_val("lp_press", 32'(press_o), 32'h1);
    seen_long = 1'b0;
    repeat (9) begin tick(); seen_long |= |long_o; end
    check_val("lp_before", 32'(seen_long), 32'h0);
    tick();
    check_val("lp_fire", 32'(long_o), 32'(c_long_exp));
    seen_long = 1'b0;
    repeat (15) begin tick(); seen_long |= |long_o; end
    check_val("lp_norepeat", 32'(seen_long), 32'h0);
    key_i = 4'hF;
    repeat (6) tick();
    check_val("lp_rel", 32'(release_o), 32'h1);
    repeat (3) tick();

    // Short hold: key_o pressed for 8 cycles only.
    key_i = 4'b1110;
    repeat (6) tick();
    check_val("sp_press", 32'(press_o), 32'h1);
    seen_long = 1'b0;
    repeat (2) begin tick(); seen_long |= |long_o; end
    key_i = 4'hF;
    repeat (6) begin tick(); seen_long |= |long_o; end
    check_val("sp_rel", 32'(release_o), 32'h1);
    repeat (10) begin tick(); seen_long |= |long_o; end
    check_val("sp_nolong", 32'(seen_long), 32'h0);

    // Reset mid-count while ch2 is already pressed.
    key_i = 4'b1011;
    repeat (6) tick();
    check_val("mr_press2", 32'(press_o), 32'h4);
    tick();
    key_i = 4'b1010;
    repeat (4) tick();
    check_val("mr_pre_key", 32'(key_o), 32'hB);
    sys_rst_n = 1'b0;
    #1;
    check_val("mr_rst_key",   32'(key_o),   32'hF);
    check_val("mr_rst_press", 32'(press_o), 32'h0);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    repeat (5) tick();
    check_val("mr_early_press", 32'(press_o), 32'h0);
    check_val("mr_early_key",   32'(key_o),   32'hF);
    tick();
    check_val("mr_press", 32'(press_o),     32'h5);
    check_val("mr_key",   32'(key_o),       32'hA);
    check_val("mr_any",   32'(any_press_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
